// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_clk_pkg
//  Description : Shared state encoding and default constants for the CPU
//                clock-enable controller.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_clk_pkg;

  // Controller states: free-run, single step, or stopped
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  // 100 MHz / 10 gives a 10 MHz effective core rate
  localparam int DIV_DEF = 10;
  // 10 ms of stability at 100 MHz before a button/switch change is accepted
  localparam int DEB_DEF = 1000000;

endpackage
`default_nettype wire

// File: rtl/cpu_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_clk_ctrl_if
//  Description : Board/core-facing signal bundle of the CPU clock-enable
//                controller. master = board and core side, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_clk_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             btn_step;
  logic             sw_run;
  logic             halt_req;
  logic             cpu_ce;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output btn_step, sw_run, halt_req,
    input  cpu_ce, running, halted, cycle_count
  );

  modport slave (
    input  btn_step, sw_run, halt_req,
    output cpu_ce, running, halted, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_clk_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_clk_ctrl_debounce
//  Description : Two-flop synchronizer followed by a stability counter. The
//                output follows the synchronized input only after it has
//                differed from the output for DEB_CYCLES consecutive cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEF
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous raw input into the clk_100MHz domain
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 != db) begin
      if (cnt == LAST) begin
        cnt <= '0;
        db  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_clk_ctrl
//  Description : Generates the RV32I core clock-enable from clk_100MHz with
//                free-run, single-step and core-requested halt, plus status
//                LEDs and a count of issued enables.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV        = DIV_DEF,
  parameter int DEB_CYCLES = DEB_DEF,
  parameter int CNT_W      = 32
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  cpu_clk_ctrl_if.slave bus
);

  localparam int             DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             step_db;
  logic             run_db;
  logic             step_db_q;
  logic             step_pulse;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             cpu_halt_lock;
  logic             lock_set;
  logic             ce_next;
  logic             cpu_ce;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  state_t           state;
  state_t           state_next;

  cpu_clk_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_db (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .raw        (bus.btn_step),
    .db         (step_db)
  );

  cpu_clk_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_db (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .raw        (bus.sw_run),
    .db         (run_db)
  );

  // A held button yields a single step: only the rising edge counts
  assign step_pulse = step_db & ~step_db_q;
  assign tick       = (div_cnt == DIV_LAST);

  // Remember the previous debounced step level for edge detection
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) step_db_q <= 1'b0;
    else       step_db_q <= step_db;
  end

  // Free-running divider, independent of controller state
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Core-requested halt latches until the run switch is seen off
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)         cpu_halt_lock <= 1'b0;
    else if (!run_db)  cpu_halt_lock <= 1'b0;
    else if (lock_set) cpu_halt_lock <= 1'b1;
  end

  // State register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= ST_HALTED;
    else       state <= state_next;
  end

  // Next-state and enable decision; run beats a simultaneous step in HALTED
  always_comb begin
    state_next = state;
    ce_next    = 1'b0;
    lock_set   = 1'b0;
    case (state)
      ST_HALTED: begin
        if (run_db && !cpu_halt_lock) state_next = ST_RUN;
        else if (step_pulse)          state_next = ST_STEP;
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_next = ST_HALTED;
          lock_set   = 1'b1;
        end else begin
          ce_next = tick;
          if (!run_db) state_next = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (tick) begin
          ce_next    = 1'b1;
          state_next = ST_HALTED;
        end
      end
      default: state_next = ST_HALTED;
    endcase
  end

  // Registered enable, status decodes and enable counter
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cpu_ce      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b1;
      cycle_count <= '0;
    end else begin
      cpu_ce  <= ce_next;
      running <= (state_next == ST_RUN);
      halted  <= (state_next == ST_HALTED);
      if (ce_next) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign bus.cpu_ce      = cpu_ce;
  assign bus.running     = running;
  assign bus.halted      = halted;
  assign bus.cycle_count = cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_clk_ctrl
//  Description : Directed bench for cpu_clk_ctrl (DIV=10, DEB_CYCLES=4,
//                CNT_W=4). Stimulus pushes expected enable pulses (cycle and
//                count) into a queue; a monitor pops them as cpu_ce appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_clk_ctrl;

  localparam int CNT_W = 4;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;

  cpu_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_clk_ctrl #(.DIV(10), .DEB_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus.slave)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Edges since reset release; the divider phase is cyc mod 10
  int cyc;
  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expect a cpu_ce pulse visible after edge c carrying the next count
  task automatic push_ce(input int c);
    exp_t e;
    exp_cnt = exp_cnt + CNT_W'(1);
    e.cyc   = c;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk_100MHz);
  endtask

  // Monitor: match every enable pulse against the scoreboard
  always @(negedge clk_100MHz) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("ce_missing_at", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.cpu_ce) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ce: got pulse at cycle %0d count %0d, required none",
                   cyc, bus.cycle_count);
        end else begin
          e = exp_q.pop_front();
          check("ce_cycle", cyc, e.cyc);
          check("ce_count", int'(bus.cycle_count), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    bus.btn_step = 1'b0;
    bus.sw_run   = 1'b0;
    bus.halt_req = 1'b0;
    exp_cnt      = '0;

    repeat (3) @(negedge clk_100MHz);
    check("rst_halted",  int'(bus.halted), 1);
    check("rst_running", int'(bus.running), 0);
    check("rst_ce",      int'(bus.cpu_ce), 0);
    check("rst_count",   int'(bus.cycle_count), 0);
    reset = 1'b0;

    // Free run: 2 sync + 4 debounce + 1 FSM edge, then ce every 10 cycles
    bus.sw_run = 1'b1;
    at(6);   check("run_early",  int'(bus.running), 0);
    at(7);   check("run_start",  int'(bus.running), 1);
             check("run_halted", int'(bus.halted), 0);
    for (int i = 1; i <= 17; i++) push_ce(10 * i);
    at(50);  check("count_5", int'(bus.cycle_count), 5);
    // 3-cycle glitch on the run switch must be filtered
    at(60);  bus.sw_run = 1'b0;
    at(63);  bus.sw_run = 1'b1;
    at(66);  check("glitch_run_a", int'(bus.running), 1);
    at(70);  check("glitch_run_b", int'(bus.running), 1);
    at(150); check("count_15", int'(bus.cycle_count), 15);
    at(160); check("count_wrap0", int'(bus.cycle_count), 0);
    at(170); check("count_wrap1", int'(bus.cycle_count), 1);
    bus.sw_run = 1'b0;
    at(176); check("run_off_late", int'(bus.running), 1);
    at(177); check("run_off_halt", int'(bus.halted), 1);
             check("run_off_run",  int'(bus.running), 0);

    // Bouncy step press: one ce after the press settles
    at(180); push_ce(200); bus.btn_step = 1'b1;
    at(181); bus.btn_step = 1'b0;
    at(182); bus.btn_step = 1'b1;
    at(183); bus.btn_step = 1'b0;
    at(184); bus.btn_step = 1'b1;
    at(190); check("step_wait_halted", int'(bus.halted), 1);
    at(191); check("step_halted", int'(bus.halted), 0);
             check("step_running", int'(bus.running), 0);
    at(200); check("step_done", int'(bus.halted), 1);
    at(204); bus.btn_step = 1'b0;
    at(215); push_ce(230); bus.btn_step = 1'b1;
    at(223); check("step2_halted", int'(bus.halted), 0);
    at(231); check("step2_done", int'(bus.halted), 1);
    at(235); bus.btn_step = 1'b0;

    // Core halt on a tick cycle suppresses that ce and locks out RUN
    at(240); bus.sw_run = 1'b1; push_ce(250); push_ce(260);
    at(247); check("run2_start", int'(bus.running), 1);
    at(269); bus.halt_req = 1'b1;
    at(270); bus.halt_req = 1'b0;
             check("halt_req_halted", int'(bus.halted), 1);
             check("halt_req_run",    int'(bus.running), 0);
             check("halt_req_count",  int'(bus.cycle_count), 5);
    // Stepping is still allowed while locked
    at(275); push_ce(290); bus.btn_step = 1'b1;
    at(285); check("lock_step", int'(bus.halted), 0);
    at(291); check("lock_back_halted", int'(bus.halted), 1);
    at(292); bus.btn_step = 1'b0;
    at(295); bus.sw_run = 1'b0;
    at(300); check("lock_held", int'(bus.halted), 1);
    at(305); bus.sw_run = 1'b1; push_ce(320); push_ce(330);
    at(311); check("resume_early", int'(bus.running), 0);
    at(312); check("resume", int'(bus.running), 1);

    // Asynchronous reset in the middle of RUN
    at(335);
    check("queue_at_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("mid_rst_ce",      int'(bus.cpu_ce), 0);
    check("mid_rst_halted",  int'(bus.halted), 1);
    check("mid_rst_running", int'(bus.running), 0);
    check("mid_rst_count",   int'(bus.cycle_count), 0);
    exp_cnt = '0;
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    push_ce(10);
    at(6);   check("rerun_early", int'(bus.running), 0);
    at(7);   check("rerun_start", int'(bus.running), 1);
    at(10);  check("rerun_count", int'(bus.cycle_count), 1);
    bus.sw_run = 1'b0;
    at(17);  check("rerun_off", int'(bus.halted), 1);
    at(40);  check("leftover_ce", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Generates the processor's execution clock-enable from clk_100MHz. Supports free-run at DIV division, single-step from a push-button, and halt on request from the core (e.g. EBREAK). Sits between the board clock/buttons and the RV32I core, which runs on clk_100MHz gated by cpu_ce. Also provides status LEDs and a retired-tick counter.

Parameters:
DIV, 10, cpu_ce period in clk_100MHz cycles (10 gives 10 MHz effective); legal range 2..2^16.
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button/switch change (10 ms).
CNT_W, 32, width of cycle_count.

Ports:
clk_100MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_step  input  1  raw step push-button, asynchronous, bouncy
sw_run  input  1  raw run switch, asynchronous, bouncy
halt_req  input  1  level from core, synchronous to clk_100MHz; 1 requests halt
cpu_ce  output  1  one-cycle clock-enable pulse to the core
running  output  1  1 while in RUN
halted  output  1  1 while in HALTED
cycle_count  output  CNT_W  number of cpu_ce pulses issued since reset

Behaviour:
- Reset (async, active-high; clock clk_100MHz): state=HALTED, cpu_ce=0, running=0, halted=1, cycle_count=0, div counter=0, both debounced values=0, both synchronizers=0, cpu_halt_lock=0.
- Input conditioning: btn_step and sw_run each pass through a 2-flop synchronizer, then a debouncer. The debounced output takes the synced value only after DEB_CYCLES consecutive cycles differing from the current output. Any mismatch-free cycle resets the stability count.
- step_pulse: one-cycle pulse on rising edge of debounced step.
- Tick: div counter free-runs 0..DIV-1, wraps to 0. tick=1 when counter==DIV-1. The counter is unaffected by state.
- FSM states: HALTED, RUN, STEP.
  - HALTED: if run_db=1 and cpu_halt_lock=0 -> RUN; else if step_pulse -> STEP.
  - RUN: on tick with halt_req=0 -> issue ce. If halt_req=1 -> HALTED, set cpu_halt_lock; no ce that cycle even on tick. Else if run_db=0 -> HALTED.
  - STEP: on tick -> issue ce, go to HALTED. halt_req is ignored in STEP.
- cpu_halt_lock: cleared when run_db=0. After a core-requested halt, the run switch must be toggled off then on to resume. Stepping remains allowed while locked.
- Priority in HALTED when run and step_pulse occur together: run wins; the step is dropped.
- cpu_ce timing: registered. Asserted exactly one cycle after the cycle in which the tick qualifies, high for exactly 1 cycle. In continuous RUN, period = DIV cycles.
- running/halted: registered decodes of state; both are 0 in STEP.
- cycle_count: increments by 1 in the same cycle cpu_ce is high; wraps modulo 2^CNT_W.
- btn_step held: produces one step only; a release plus a new press is needed for the next.

Decomposition:
- Package cpu_clk_pkg: state encoding (HALTED=2'd0, RUN=2'd1, STEP=2'd2) and default constants DIV_DEF=10, DEB_DEF=1000000.
- Sub-module debounce, parameter DEB_CYCLES. It contains the synchronizer plus the stability counter, and is instantiated twice (step, run).
- Top holds the tick counter, FSM, edge detector, lock flag, and counter.

Test Plan:
All scenarios use DIV=10, DEB_CYCLES=4.
1. Reset asserted mid-RUN, cpu_ce pulsing -> next edge: cpu_ce=0, halted=1, cycle_count=0; no ce until run re-debounced.
2. sw_run=1 held -> running=1 after sync+4 stable cycles; cpu_ce pulses every 10 cycles, each 1 cycle wide; 5 pulses -> cycle_count=5.
3. From HALTED, press btn_step (bounce 0/1/0/1, then stable 1 for 20 cycles) -> exactly one cpu_ce, state returns HALTED, cycle_count +1. Release and press again -> second ce.
4. In RUN, assert halt_req for 1 cycle coinciding with tick -> no ce that tick, halted=1. sw_run still 1 -> stays HALTED. Toggle sw_run 0 then 1 (each debounced) -> RUN resumes.
5. Glitch on sw_run shorter than 4 cycles while in RUN -> no state change, ce cadence unbroken.
6. CNT_W=4, run 17 ce pulses -> cycle_count wraps 15 -> 0 -> 1.
